rsa_exp_ctrl: RTL

RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

---
 rtl/rsa_exp_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right binary square-and-multiply controller for modular exponentiation.
// Drives a shared modular multiplier through a req/ack handshake and reports base^exp mod n.
module rsa_exp_ctrl #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned EXP_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    output logic             mul_req,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic             mul_ack,
    input  logic [WIDTH-1:0] mul_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [15:0]      op_cnt
);

    localparam int unsigned IdxW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StNext,
        StSq,
        StMul,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  base_q, base_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [15:0]       op_cnt_q, op_cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              gap_q, gap_d;

    logic exp_bit;
    logic idx_zero;
    logic ack_ok;

    assign exp_bit  = exp_q[idx_q];
    assign idx_zero = (idx_q == '0);
    // Acks are only meaningful while a request is actually being presented.
    assign ack_ok   = mul_req & mul_ack;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (exp_bit) begin
                    state_d = StNext;
                end else if (idx_zero) begin
                    state_d = StDone;
                end
            end
            StNext: begin
                state_d = idx_zero ? StDone : StSq;
            end
            StSq: begin
                if (ack_ok) begin
                    state_d = exp_bit ? StMul : StNext;
                end
            end
            StMul: begin
                if (ack_ok) begin
                    state_d = StNext;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs; gap_q forces one request-free cycle after every accepted ack
    always_comb begin
        mul_req = 1'b0;
        mul_a   = '0;
        mul_b   = '0;
        busy    = 1'b0;
        done    = 1'b0;
        if (!reset) begin
            busy = (state_q != StIdle);
            done = (state_q == StDone);
            if ((state_q == StSq || state_q == StMul) && !gap_q) begin
                mul_req = 1'b1;
                mul_a   = acc_q;
                mul_b   = (state_q == StSq) ? acc_q : base_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            op_cnt_q <= '0;
            result_q <= '0;
            gap_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            op_cnt_q <= op_cnt_d;
            result_q <= result_d;
            gap_q    <= gap_d;
        end
    end

    // Datapath next-state logic
    always_comb begin
        base_d   = base_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        op_cnt_d = op_cnt_q;
        result_d = result_q;
        gap_d    = ack_ok;

        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d   = base;
                    exp_d    = exp;
                    acc_d    = WIDTH'(1);
                    idx_d    = IdxW'(EXP_W - 1);
                    op_cnt_d = '0;
                end
            end
            StScan: begin
                if (exp_bit) begin
                    acc_d = base_q;
                end else if (!idx_zero) begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StNext: begin
                if (!idx_zero) begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StSq, StMul: begin
                if (ack_ok) begin
                    acc_d    = mul_result;
                    op_cnt_d = (op_cnt_q == 16'hFFFF) ? op_cnt_q : op_cnt_q + 16'd1;
                end
            end
            default: begin
            end
        endcase

        // Capture on entry to DONE so result is already valid while done is high.
        if (state_d == StDone && state_q != StDone) begin
            result_d = acc_q;
        end
    end

    assign result = result_q;
    assign op_cnt = op_cnt_q;

endmodule
